bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width.
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits.
REQ-003 SHALL have port tg, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, conversion request, sampled each rising edge.
REQ-006 SHALL have port bin, input, WIDTH, binary value (0..2^WIDTH-1), captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when bcd/ovf are updated.
REQ-009 SHALL have port bcd, output, 4*DIGITS, packed digits, [3:0] units up to [15:12] thousands.
REQ-010 SHALL have port ovf, output, 1, set with done when the captured value exceeded 10^DIGITS-1.

Function
REQ-011 SHALL implement a sequential shift-add-3 (double-dabble) converter, one bit per clock.
REQ-012 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on accepted start, SHIFT->DONE after WIDTH shift steps, DONE->IDLE after one cycle, or DONE->SHIFT if start is high in DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start high in SHIFT SHALL be ignored, not queued.
REQ-014 SHALL, on acceptance at edge k, capture bin, clear the internal scratch register and set busy from edge k.
REQ-015 SHALL perform the WIDTH shift steps at edges k+1..k+WIDTH; each step adds 3 to every scratch digit >= 5, then shifts left one bit, MSB of bin first.
REQ-016 SHALL register bcd, ovf and done=1 at edge k+WIDTH+1 (latency WIDTH+1 = 15 cycles), clearing busy at the same edge.
REQ-017 SHALL hold bcd and ovf stable between done pulses; done SHALL be high for exactly one cycle per conversion.
REQ-018 SHALL keep scratch register wide enough (WIDTH + 4*(DIGITS+1) bits) that no intermediate carry is lost for any 14-bit input.
REQ-019 SHALL support back-to-back conversions, one per WIDTH+1 cycles, when start is held high.
REQ-020 SHALL treat 9999 as a valid boundary (ovf=0) and 10000 as the first overflow value.

Reset
REQ-021 SHALL, while rst_n=0 at a rising edge, set state=IDLE, busy=0, done=0, ovf=0, bcd=0, scratch=0.
REQ-022 SHALL abort any conversion in progress on reset, with no done pulse for the aborted request.
REQ-023 SHALL ignore start in any cycle where rst_n=0.

Configuration
REQ-024 SHALL use macro BIN2BCD_SAT_EN to select overflow handling.
REQ-025 SHALL, with BIN2BCD_SAT_EN defined, clamp inputs > 9999 to 9999 at capture, output bcd=16'h9999 and ovf=1; latency unchanged.
REQ-026 SHALL, without BIN2BCD_SAT_EN, convert inputs > 9999 normally but output bcd=16'hFFFF (per-digit blank code 4'hF for the downstream display driver) and ovf=1.

Structure
REQ-027 SHALL place state enum, WIDTH/DIGITS defaults, MAX_VAL=9999 and BLANK_DIGIT=4'hF in shared package bin2bcd_pkg.
REQ-028 SHALL instantiate sub-module bcd_digit_adj (4-bit in/out, add 3 when >= 5) once per scratch digit.

Verification
REQ-029 SHALL cover: bin=0, start pulse -> done 15 cycles later, bcd=16'h0000, ovf=0.
REQ-030 SHALL cover: bin=1234 -> bcd=16'h1234, busy high 15 cycles, done for exactly 1 cycle.
REQ-031 SHALL cover: bin=9999 -> bcd=16'h9999, ovf=0; bin=10000 -> ovf=1, bcd=16'h9999 with macro, 16'hFFFF without.
REQ-032 SHALL cover: start pulses at cycles 3 and 8 of a conversion of 42 -> only one done, bcd=16'h0042.
REQ-033 SHALL cover: rst_n low at cycle 7 of a conversion of 5555 -> no done, all outputs 0; next start with 77 -> bcd=16'h0077.
REQ-034 SHALL cover: start held high, inputs 0..9999 ascending -> each done carries the correct BCD, one result per 15 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// ----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_t      - converter FSM states (IDLE, SHIFT, DONE)
//   WIDTH_DEF    - default binary input width
//   DIGITS_DEF   - default number of BCD output digits
//   MAX_VAL      - largest value representable in DIGITS_DEF digits (9999)
//   BLANK_DIGIT  - per-digit code the display driver renders as blank
//   add3_adjust  - double-dabble digit correction (add 3 when >= 5)
// ----------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF  = 14;
    localparam int DIGITS_DEF = 4;
    localparam int MAX_VAL    = 9999;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // A digit >= 5 would become >= 10 after the next doubling, so it is
    // pre-corrected by 3 so that the carry lands in the next digit.
    function automatic logic [3:0] add3_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational correction for one BCD digit of the double-dabble scratch
// register: adds 3 when the digit is 5 or more, passes it through otherwise.
// Ports:
//   digit    - 4-bit scratch digit before the shift step
//   adjusted - 4-bit corrected digit
// ----------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = add3_adjust(digit);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter, one input
// bit per clock. A conversion takes WIDTH+1 cycles from the accepting edge
// to the done pulse; holding start high gives back-to-back conversions.
//
// Ports:
//   tg     - clock, all state changes on its rising edge
//   rst_n  - synchronous active-low reset
//   start  - conversion request, accepted in IDLE or DONE only
//   bin    - binary value, captured when start is accepted
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd/ovf are updated
//   bcd    - packed BCD digits, [3:0] units upward
//   ovf    - captured value exceeded MAX_VAL (valid with done, then held)
//
// Configuration macro BIN2BCD_SAT_EN:
//   defined   - inputs above MAX_VAL are clamped at capture; bcd shows 9999
//   undefined - inputs above MAX_VAL convert normally, bcd shows all blank
//               digits (BLANK_DIGIT) for the display driver
//   ovf is raised in both builds; latency is the same.
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                tg,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    // One spare digit above the output digits keeps the carry of any
    // WIDTH-bit input; the low WIDTH bits hold the not-yet-shifted input.
    localparam int NDIG  = DIGITS + 1;
    localparam int SCR_W = WIDTH + 4 * NDIG;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last_step;
    logic               over_max;
    logic               ovf_pend;
    logic [WIDTH-1:0]   bin_cap;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   step_cnt;
    logic               unused_adj_msb;

    // ---------------- digit correction ahead of each shift ------------------
    assign scratch_adj[WIDTH-1:0] = scratch[WIDTH-1:0];

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[WIDTH + 4*i +: 4]),
            .adjusted (scratch_adj[WIDTH + 4*i +: 4])
        );
    end

    // The top bit is shifted out on every step and never reaches a digit.
    assign unused_adj_msb = scratch_adj[SCR_W-1];

    // ---------------- capture path -----------------------------------------
    assign over_max = (32'(bin) > MAX_VAL);

`ifdef BIN2BCD_SAT_EN
    assign bin_cap = over_max ? WIDTH'(MAX_VAL) : bin;
`else
    assign bin_cap = bin;
`endif

    assign last_step = (step_cnt == CNT_W'(WIDTH - 1));

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge tg) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here: requests made
                // mid-conversion are dropped, not queued.
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath and registered outputs ----------------------
    always_ff @(posedge tg) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // sees the pre-edge values of the others regardless of statement order.
        if (!rst_n) begin
            scratch  <= '0;
            step_cnt <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
                ovf  <= ovf_pend;
`ifdef BIN2BCD_SAT_EN
                bcd  <= scratch[WIDTH +: 4*DIGITS];
`else
                bcd  <= ovf_pend ? {DIGITS{BLANK_DIGIT}}
                                 : scratch[WIDTH +: 4*DIGITS];
`endif
            end

            // Placed after the DONE block so a back-to-back accept keeps
            // busy high across the done edge.
            if (accept) begin
                scratch  <= {{(4*NDIG){1'b0}}, bin_cap};
                step_cnt <= '0;
                ovf_pend <= over_max;
                busy     <= 1'b1;
            end else if (state == SHIFT) begin
                scratch  <= {scratch_adj[SCR_W-2:0], 1'b0};
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end
    end

endmodule
